// File: rtl/sbox_arbiter_pkg.sv
// rtl/sbox_arbiter_pkg.sv - shared types and widths for the S-box arbiter
package sbox_arbiter_pkg;

  localparam int NLANES  = 4;
  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } state_t;

  // Which requester received the most recent grant
  typedef enum logic {
    GRANT_KEY = 1'b0,
    GRANT_ST  = 1'b1
  } grant_t;

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - single-byte FIPS-197 forward S-box, purely combinational
module sbox (
  input  logic [7:0] code,
  output logic [7:0] subst
);

  // Row r holds S(r0)..S(rf), S(r0) in the top byte
  localparam logic [127:0] ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] row;
  logic [6:0]   shift;

  always_comb begin
    row   = ROWS[code[7:4]];
    shift = {~code[3:0], 3'b000};
    subst = row[shift +: 8];
  end

endmodule

// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - shares one 4-lane S-box bank between SubBytes and SubWord requesters
module sbox_arbiter
  import sbox_arbiter_pkg::*;
#(
  parameter int NLANES = sbox_arbiter_pkg::NLANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [STATE_W-1:0]   st_data,
  output logic                 st_out_valid,
  output logic [STATE_W-1:0]   st_out_data,
  input  logic                 kw_valid,
  output logic                 kw_ready,
  input  logic [WORD_W-1:0]    kw_data,
  output logic                 kw_out_valid,
  output logic [WORD_W-1:0]    kw_out_data,
  output logic                 busy
);

  state_t              state;
  state_t              state_nx;
  grant_t              last_grant;
  logic [1:0]          word_cnt;
  logic [STATE_W-1:0]  st_lat;
  logic [WORD_W-1:0]   kw_lat;
  logic [WORD_W-1:0]   mux_word;
  logic [WORD_W-1:0]   sub_word;
  logic                idle;

  assign idle = (state == IDLE);
  assign busy = !idle;

  // On a tie the requester that did not win last time is granted
  always_comb begin
    st_ready = 1'b0;
    kw_ready = 1'b0;
    if (idle) begin
      if (st_valid && (!kw_valid || last_grant == GRANT_KEY)) begin
        st_ready = 1'b1;
      end else if (kw_valid) begin
        kw_ready = 1'b1;
      end
    end
  end

  always_comb begin
    mux_word = kw_lat;
    if (state == ST_RUN) begin
      case (word_cnt)
        2'd0:    mux_word = st_lat[127:96];
        2'd1:    mux_word = st_lat[95:64];
        2'd2:    mux_word = st_lat[63:32];
        default: mux_word = st_lat[31:0];
      endcase
    end
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    sbox u_sbox (
      .code  (mux_word[8*i +: 8]),
      .subst (sub_word[8*i +: 8])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (st_ready) begin
          state_nx = ST_RUN;
        end else if (kw_ready) begin
          state_nx = KW_RUN;
        end
      end
      ST_RUN: begin
        if (word_cnt == 2'd3) begin
          state_nx = IDLE;
        end
      end
      KW_RUN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= GRANT_KEY;
      word_cnt     <= 2'd0;
      st_lat       <= '0;
      kw_lat       <= '0;
      st_out_data  <= '0;
      kw_out_data  <= '0;
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
    end else begin
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (st_ready) begin
            st_lat     <= st_data;
            last_grant <= GRANT_ST;
            word_cnt   <= 2'd0;
          end else if (kw_ready) begin
            kw_lat     <= kw_data;
            last_grant <= GRANT_KEY;
          end
        end
        ST_RUN: begin
          // Result is built up word by word; only the final pulse marks it complete
          case (word_cnt)
            2'd0:    st_out_data[127:96] <= sub_word;
            2'd1:    st_out_data[95:64]  <= sub_word;
            2'd2:    st_out_data[63:32]  <= sub_word;
            default: st_out_data[31:0]   <= sub_word;
          endcase
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            st_out_valid <= 1'b1;
          end
        end
        KW_RUN: begin
          kw_out_data  <= sub_word;
          kw_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb/tb_sbox_arbiter.sv - scoreboard bench for sbox_arbiter with an algebraic S-box reference
module tb_sbox_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [127:0] st_data = '0;
  logic         st_out_valid;
  logic [127:0] st_out_data;
  logic         kw_valid = 1'b0;
  logic         kw_ready;
  logic [31:0]  kw_data = '0;
  logic         kw_out_valid;
  logic [31:0]  kw_out_data;
  logic         busy;

  sbox_arbiter #(.NLANES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_data      (st_data),
    .st_out_valid (st_out_valid),
    .st_out_data  (st_out_data),
    .kw_valid     (kw_valid),
    .kw_ready     (kw_ready),
    .kw_data      (kw_data),
    .kw_out_valid (kw_out_valid),
    .kw_out_data  (kw_out_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t st_q[$];
  exp_t kw_q[$];
  int   grant_log[$];
  bit   log_en = 1'b0;
  int   free_cyc = 0;
  bit   last_key = 1'b1;
  logic [7:0] sb [256];

  task automatic check(input string name, input bit ok, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    if (v == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] model_st(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] model_kw(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[d[8*i +: 8]];
    return r;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Model: bank is free again a fixed number of cycles after each grant
  bit   m_idle, m_es, m_ek;
  exp_t m_e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      st_q.delete();
      kw_q.delete();
      free_cyc = 0;
      last_key = 1'b1;
    end else begin
      m_idle = (cyc >= free_cyc);
      m_es   = m_idle && st_valid && (!kw_valid || last_key);
      m_ek   = m_idle && kw_valid && !m_es;
      check("handshake", {busy, st_ready, kw_ready} == {!m_idle, m_es, m_ek},
            {busy, st_ready, kw_ready}, {!m_idle, m_es, m_ek});
      if (m_es) begin
        m_e.data = model_st(st_data); m_e.due = cyc + 5; st_q.push_back(m_e);
        free_cyc = cyc + 5; last_key = 1'b0;
        if (log_en) grant_log.push_back(0);
      end else if (m_ek) begin
        m_e.data = {96'h0, model_kw(kw_data)}; m_e.due = cyc + 2; kw_q.push_back(m_e);
        free_cyc = cyc + 2; last_key = 1'b1;
        if (log_en) grant_log.push_back(1);
      end
      if (st_out_valid) begin
        if (st_q.size() == 0) check("st_unexpected", 1'b0, st_out_data, 0);
        else begin
          m_e = st_q.pop_front();
          check("st_data", st_out_data == m_e.data, st_out_data, m_e.data);
          check("st_latency", cyc == m_e.due, cyc, m_e.due);
        end
      end else if (st_q.size() > 0 && cyc >= st_q[0].due) begin
        m_e = st_q.pop_front();
        check("st_missing", 1'b0, 0, m_e.data);
      end
      if (kw_out_valid) begin
        if (kw_q.size() == 0) check("kw_unexpected", 1'b0, kw_out_data, 0);
        else begin
          m_e = kw_q.pop_front();
          check("kw_data", {96'h0, kw_out_data} == m_e.data, kw_out_data, m_e.data);
          check("kw_latency", cyc == m_e.due, cyc, m_e.due);
        end
      end else if (kw_q.size() > 0 && cyc >= kw_q[0].due) begin
        m_e = kw_q.pop_front();
        check("kw_missing", 1'b0, 0, m_e.data);
      end
    end
  end

  task automatic wait_ready(input bit for_st, output int t);
    bit got;
    got = 1'b0;
    t = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (for_st ? st_ready : kw_ready) begin got = 1'b1; t = cyc; end
    end
    if (!got) check(for_st ? "st_accept_timeout" : "kw_accept_timeout", 1'b0, 0, 1);
  endtask

  task automatic st_dir(input logic [127:0] d, input logic [127:0] want);
    int t0;
    bit got;
    @(posedge clk); #1;
    st_valid = 1'b1; st_data = d;
    wait_ready(1'b1, t0);
    @(posedge clk); #1;
    st_valid = 1'b0; st_data = {$urandom, $urandom, $urandom, $urandom};
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (st_out_valid) got = 1'b1;
    end
    check("st_dir_seen", got, got, 1);
    check("st_dir_data", st_out_data == want, st_out_data, want);
    check("st_dir_cycles", cyc - t0 == 5, cyc - t0, 5);
  endtask

  task automatic kw_dir(input logic [31:0] d, input logic [31:0] want);
    int t0;
    bit got;
    @(posedge clk); #1;
    kw_valid = 1'b1; kw_data = d;
    wait_ready(1'b0, t0);
    @(posedge clk); #1;
    kw_valid = 1'b0; kw_data = $urandom;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (kw_out_valid) got = 1'b1;
    end
    check("kw_dir_seen", got, got, 1);
    check("kw_dir_data", kw_out_data == want, kw_out_data, want);
    check("kw_dir_cycles", cyc - t0 == 2, cyc - t0, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    for (int i = 0; i < 256; i++) sb[i] = ref_sbox(i[7:0]);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {st_out_valid, kw_out_valid, busy, st_ready, kw_ready, st_out_data, kw_out_data} == '0,
          {st_out_valid, kw_out_valid, busy, st_ready, kw_ready}, 0);
    check("reset_data", st_out_data == '0 && kw_out_data == '0, st_out_data ^ {96'h0, kw_out_data}, 0);
    #1 rst_n = 1'b1;

    st_dir(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
    kw_dir(32'hcf4f3c09, 32'h8a84eb01);
    kw_dir(32'h53535353, 32'hedededed);
    kw_dir(32'h00000000, 32'h63636363);
    kw_dir(32'hffffffff, 32'h16161616);

    // Key request raised while the state op is running
    @(posedge clk); #1;
    st_valid = 1'b1; st_data = {$urandom, $urandom, $urandom, $urandom};
    wait_ready(1'b1, t0);
    @(posedge clk); #1;
    st_valid = 1'b0; kw_valid = 1'b1; kw_data = $urandom;
    wait_ready(1'b0, t1);
    check("kw_after_st", t1 - t0 == 5, t1 - t0, 5);
    @(posedge clk); #1;
    kw_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Reset in the second run cycle of a state op
    #1;
    st_valid = 1'b1; st_data = {$urandom, $urandom, $urandom, $urandom};
    wait_ready(1'b1, t0);
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {st_out_valid, kw_out_valid, busy, st_ready, kw_ready} == '0,
          {st_out_valid, kw_out_valid, busy, st_ready, kw_ready}, 0);
    check("midreset_data", st_out_data == '0 && kw_out_data == '0, st_out_data ^ {96'h0, kw_out_data}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Both requesters held: grants must alternate, state first after reset
    grant_log.delete();
    log_en = 1'b1;
    #1;
    st_valid = 1'b1; kw_valid = 1'b1;
    for (int n = 0; n < 24; n++) begin
      st_data = {$urandom, $urandom, $urandom, $urandom};
      kw_data = $urandom;
      @(posedge clk); #1;
    end
    st_valid = 1'b0; kw_valid = 1'b0;
    log_en = 1'b0;
    check("tie_grant_count", grant_log.size() >= 4, grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++)
      check("tie_grant_order", grant_log[i] == (i % 2), grant_log[i], i % 2);
    repeat (8) @(posedge clk);

    // Every byte value through every lane
    for (int b = 0; b < 256; b++) begin
      @(posedge clk); #1;
      kw_valid = 1'b1; kw_data = {4{b[7:0]}};
      wait_ready(1'b0, t0);
      @(posedge clk); #1;
      kw_valid = 1'b0; kw_data = $urandom;
    end
    repeat (4) @(posedge clk);

    // Random valids and data, including drops before acceptance and changes after
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      st_valid = ($urandom_range(0, 3) == 0);
      kw_valid = ($urandom_range(0, 2) == 0);
      st_data  = {$urandom, $urandom, $urandom, $urandom};
      kw_data  = $urandom;
    end
    @(posedge clk); #1;
    st_valid = 1'b0; kw_valid = 1'b0;
    repeat (12) @(posedge clk);

    check("st_queue_drained", st_q.size() == 0, st_q.size(), 0);
    check("kw_queue_drained", kw_q.size() == 0, kw_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
